// File: rtl/riscv_v_permutation_ctrl.sv
// Sequencing controller for the vector permutation ALU (vmv.x.s / vmv.s.x).
// Takes one request at a time, holds the ALU inputs for ALU_LAT cycles,
// captures the result and presents it on the integer or vector writeback
// channel until that channel accepts it.
//
// Handshake rule: a transfer happens on a rising clock edge where both valid
// and ready are high. A valid, once raised, stays high with stable data until
// that transfer. A ready seen while valid is low does nothing.
//
// Optional build macro RISCV_V_PERM_PERF_EN adds three 32-bit wrapping
// performance counters: v2i completions, i2v completions, writeback stalls.
module riscv_v_permutation_ctrl #(
    parameter int INT_W   = 32,
    parameter int VEC_W   = 128,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_is_v2i,
    input  logic             req_is_i2v,
    input  logic [INT_W-1:0] req_int_data,
    input  logic [VEC_W-1:0] req_vec_data,
    output logic             alu_is_v2i,
    output logic             alu_is_i2v,
    output logic [INT_W-1:0] alu_int_data,
    output logic [VEC_W-1:0] alu_vec_data,
    input  logic [INT_W-1:0] alu_int_result,
    input  logic [VEC_W-1:0] alu_vec_result,
    output logic             int_wb_valid,
    input  logic             int_wb_ready,
    output logic [INT_W-1:0] int_wb_data,
    output logic             vec_wb_valid,
    input  logic             vec_wb_ready,
    output logic [VEC_W-1:0] vec_wb_data,
    output logic             illegal_req,
    output logic [1:0]       fsm_state
`ifdef RISCV_V_PERM_PERF_EN
    ,
    output logic [31:0]      perf_v2i_cnt,
    output logic [31:0]      perf_i2v_cnt,
    output logic [31:0]      perf_stall_cnt
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] WB   = 2'd2;

    // The counter counts down from ALU_LAT-1, so the ALU inputs are held for
    // exactly ALU_LAT cycles (ALU_LAT is limited to 1..15).
    localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

    logic [1:0]       state;
    logic [3:0]       cnt;
    logic             lat_v2i;
    logic             lat_i2v;
    logic [INT_W-1:0] lat_int;
    logic [VEC_W-1:0] lat_vec;
    logic [INT_W-1:0] wb_int;
    logic [VEC_W-1:0] wb_vec;
    logic             illegal_q;
    logic             accept;
    logic             legal;
    logic             wb_done;
    logic             in_exec;

    assign req_ready = (state == IDLE);
    assign accept    = req_valid & req_ready;
    assign legal     = req_is_v2i ^ req_is_i2v;
    assign in_exec   = (state == EXEC);

    assign alu_is_v2i   = in_exec & lat_v2i;
    assign alu_is_i2v   = in_exec & lat_i2v;
    assign alu_int_data = in_exec ? lat_int : '0;
    assign alu_vec_data = in_exec ? lat_vec : '0;

    // Only one of the latched flags can be set, so the valids are exclusive.
    assign int_wb_valid = (state == WB) & lat_v2i;
    assign vec_wb_valid = (state == WB) & lat_i2v;
    assign int_wb_data  = wb_int;
    assign vec_wb_data  = wb_vec;
    assign wb_done      = (int_wb_valid & int_wb_ready) | (vec_wb_valid & vec_wb_ready);

    assign illegal_req = illegal_q;
    assign fsm_state   = state;

    // Main sequencer: accept, hold ALU inputs, capture result, write back.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            lat_v2i   <= 1'b0;
            lat_i2v   <= 1'b0;
            lat_int   <= '0;
            lat_vec   <= '0;
            wb_int    <= '0;
            wb_vec    <= '0;
            illegal_q <= 1'b0;
        end else begin
            // Illegal requests are consumed in IDLE and flagged one cycle later.
            illegal_q <= accept & ~legal;
            case (state)
                IDLE: begin
                    if (accept && legal) begin
                        lat_v2i <= req_is_v2i;
                        lat_i2v <= req_is_i2v;
                        lat_int <= req_int_data;
                        lat_vec <= req_vec_data;
                        cnt     <= LAT_M1;
                        state   <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == 4'd0) begin
                        if (lat_v2i) wb_int <= alu_int_result;
                        else         wb_vec <= alu_vec_result;
                        state <= WB;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                WB: begin
                    if (wb_done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RISCV_V_PERM_PERF_EN
    logic stall;
    assign stall = (int_wb_valid & ~int_wb_ready) | (vec_wb_valid & ~vec_wb_ready);

    // Performance counters; natural 32-bit wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_v2i_cnt   <= '0;
            perf_i2v_cnt   <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (int_wb_valid & int_wb_ready) perf_v2i_cnt   <= perf_v2i_cnt + 32'd1;
            if (vec_wb_valid & vec_wb_ready) perf_i2v_cnt   <= perf_i2v_cnt + 32'd1;
            if (stall)                       perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_riscv_v_permutation_ctrl.sv
// Bench for riscv_v_permutation_ctrl: directed requests feed an expected
// queue; a negedge monitor pops and checks each writeback handshake.
module tb_riscv_v_permutation_ctrl;

    localparam int INT_W   = 32;
    localparam int VEC_W   = 128;
    localparam int ALU_LAT = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             req_is_v2i = 1'b0;
    logic             req_is_i2v = 1'b0;
    logic [INT_W-1:0] req_int_data = '0;
    logic [VEC_W-1:0] req_vec_data = '0;
    logic             alu_is_v2i;
    logic             alu_is_i2v;
    logic [INT_W-1:0] alu_int_data;
    logic [VEC_W-1:0] alu_vec_data;
    logic [INT_W-1:0] alu_int_result;
    logic [VEC_W-1:0] alu_vec_result;
    logic             int_wb_valid;
    logic             int_wb_ready = 1'b0;
    logic [INT_W-1:0] int_wb_data;
    logic             vec_wb_valid;
    logic             vec_wb_ready = 1'b0;
    logic [VEC_W-1:0] vec_wb_data;
    logic             illegal_req;
    logic [1:0]       fsm_state;
`ifdef RISCV_V_PERM_PERF_EN
    logic [31:0]      perf_v2i_cnt;
    logic [31:0]      perf_i2v_cnt;
    logic [31:0]      perf_stall_cnt;
`endif

    riscv_v_permutation_ctrl #(.INT_W(INT_W), .VEC_W(VEC_W), .ALU_LAT(ALU_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_is_v2i(req_is_v2i), .req_is_i2v(req_is_i2v),
        .req_int_data(req_int_data), .req_vec_data(req_vec_data),
        .alu_is_v2i(alu_is_v2i), .alu_is_i2v(alu_is_i2v),
        .alu_int_data(alu_int_data), .alu_vec_data(alu_vec_data),
        .alu_int_result(alu_int_result), .alu_vec_result(alu_vec_result),
        .int_wb_valid(int_wb_valid), .int_wb_ready(int_wb_ready), .int_wb_data(int_wb_data),
        .vec_wb_valid(vec_wb_valid), .vec_wb_ready(vec_wb_ready), .vec_wb_data(vec_wb_data),
        .illegal_req(illegal_req), .fsm_state(fsm_state)
`ifdef RISCV_V_PERM_PERF_EN
        ,
        .perf_v2i_cnt(perf_v2i_cnt), .perf_i2v_cnt(perf_i2v_cnt), .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    // ALU model: a move returns the operand; junk when the matching flag is off.
    assign alu_int_result = alu_is_v2i ? alu_vec_data[INT_W-1:0] : 32'hbad0_bad0;
    assign alu_vec_result = alu_is_i2v ? {96'h0, alu_int_data} : {4{32'hbad0_bad0}};

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_miss = 0;
    logic [VEC_W:0] exp_q[$];   // {is_v2i, data}
    int m_v2i = 0, m_i2v = 0, m_stall = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per writeback handshake.
    always @(negedge clk) begin
        logic [VEC_W:0] e;
        if (!rst_n) begin
            m_v2i = 0; m_i2v = 0; m_stall = 0;
        end else begin
            if (int_wb_valid && vec_wb_valid) chk("both_valid", 1, 0);
            if (int_wb_valid || vec_wb_valid) begin
                if (exp_q.size() == 0) chk("unexpected_wb", 1, 0);
                else if (int_wb_valid ? int_wb_ready : vec_wb_ready) begin
                    e = exp_q.pop_front();
                    chk("wb_type", {127'h0, int_wb_valid}, {127'h0, e[VEC_W]});
                    chk("wb_data", int_wb_valid ? {96'h0, int_wb_data} : vec_wb_data, e[VEC_W-1:0]);
                    if (int_wb_valid) m_v2i++; else m_i2v++;
                end else m_stall++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_ready();
        int k = 0;
        @(negedge clk);
        while (!req_ready && k < 40) begin @(negedge clk); k++; end
        if (k >= 40) chk("req_ready_timeout", 0, 1);
    endtask

    // Issues one request; returns just after the accepting edge.
    task automatic issue(input logic v2i, input logic i2v, input logic [INT_W-1:0] id,
                         input logic [VEC_W-1:0] vd);
        @(posedge clk) #1;
        req_is_v2i = v2i; req_is_i2v = i2v; req_int_data = id; req_vec_data = vd;
        req_valid = 1'b1;
        wait_ready();
        @(posedge clk);
        if (v2i ^ i2v) exp_q.push_back(v2i ? {1'b1, 96'h0, vd[INT_W-1:0]} : {1'b0, 96'h0, id});
        #1 req_valid = 1'b0;
    endtask

    task automatic check_reset();
        chk("rst_req_ready", {127'h0, req_ready}, 1);
        chk("rst_alu_flags", {126'h0, alu_is_v2i, alu_is_i2v}, 0);
        chk("rst_alu_int", {96'h0, alu_int_data}, 0);
        chk("rst_alu_vec", alu_vec_data, 0);
        chk("rst_wb_valid", {126'h0, int_wb_valid, vec_wb_valid}, 0);
        chk("rst_int_wb_data", {96'h0, int_wb_data}, 0);
        chk("rst_vec_wb_data", vec_wb_data, 0);
        chk("rst_illegal", {127'h0, illegal_req}, 0);
        chk("rst_state", {126'h0, fsm_state}, 0);
`ifdef RISCV_V_PERM_PERF_EN
        chk("rst_perf", {32'h0, perf_v2i_cnt, perf_i2v_cnt, perf_stall_cnt}, 0);
`endif
    endtask

    task automatic illegal(input logic v2i, input logic i2v);
        @(posedge clk) #1;
        req_is_v2i = v2i; req_is_i2v = i2v; req_valid = 1'b1;
        @(negedge clk) chk("ill_req_ready", {127'h0, req_ready}, 1);
        @(posedge clk) #1 req_valid = 1'b0;
        @(negedge clk);
        chk("ill_pulse", {127'h0, illegal_req}, 1);
        chk("ill_no_alu", {126'h0, alu_is_v2i, alu_is_i2v}, 0);
        chk("ill_ready_kept", {127'h0, req_ready}, 1);
        @(negedge clk) chk("ill_pulse_end", {127'h0, illegal_req}, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [VEC_W-1:0] d0;
        int k, n_alu, n_other, n_rdy;
        int acc[4];

        repeat (3) @(posedge clk);
        @(negedge clk) check_reset();
        @(posedge clk) #1 rst_n = 1'b1;

        // v2i: latency ALU_LAT+1 after accept, ALU flag held ALU_LAT cycles.
        int_wb_ready = 1'b1;
        issue(1'b1, 1'b0, 32'h0, 128'h0123_4567_89ab_cdef_0000_0000_dead_beef);
        k = 0; n_alu = 0; n_other = 0;
        do begin
            @(negedge clk); k++;
            if (alu_is_v2i) n_alu++;
            if (vec_wb_valid || alu_is_i2v) n_other++;
        end while (!int_wb_valid && k < 40);
        chk("v2i_latency", k, ALU_LAT + 1);
        chk("v2i_alu_cycles", n_alu, ALU_LAT);
        chk("v2i_other_chan", n_other, 0);
        @(negedge clk) chk("v2i_valid_drop", {127'h0, int_wb_valid}, 0);

        // i2v with vector writeback stalled for 4 cycles; int ready is ignored.
        vec_wb_ready = 1'b0;
        issue(1'b0, 1'b1, 32'h1234_5678, {4{32'hffff_ffff}});
        k = 0; n_rdy = 0;
        do begin
            @(negedge clk); k++;
            if (req_ready) n_rdy++;
        end while (!vec_wb_valid && k < 40);
        chk("i2v_latency", k, ALU_LAT + 1);
        chk("i2v_ready_low", n_rdy, 0);
        d0 = vec_wb_data;
        chk("i2v_data", d0, 128'h1234_5678);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("i2v_hold_valid", {127'h0, vec_wb_valid}, 1);
            chk("i2v_hold_data", vec_wb_data, d0);
            chk("i2v_hold_ready", {127'h0, req_ready}, 0);
        end
        @(posedge clk) #1 vec_wb_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("i2v_valid_drop", {127'h0, vec_wb_valid}, 0);
        chk("i2v_back_idle", {127'h0, req_ready}, 1);

        // Illegal: both flags, then neither.
        illegal(1'b1, 1'b1);
        illegal(1'b0, 1'b0);

        // Back-to-back with req_valid held high.
        @(posedge clk) #1 req_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_is_v2i = (i % 2 == 0);
            req_is_i2v = (i % 2 != 0);
            req_int_data = 32'ha5a5_0000 + i;
            req_vec_data = {4{32'h1000_0000 + i}};
            wait_ready();
            @(posedge clk);
            exp_q.push_back((i % 2 == 0) ? {1'b1, 96'h0, 32'h1000_0000 + i}
                                         : {1'b0, 96'h0, 32'ha5a5_0000 + i});
            #1 acc[i] = cyc;
        end
        req_valid = 1'b0;
        for (int i = 1; i < 4; i++) chk("b2b_spacing", acc[i] - acc[i-1], ALU_LAT + 2);
        k = 0;
        while (exp_q.size() != 0 && k < 50) begin @(negedge clk); k++; end
        chk("b2b_drain", exp_q.size(), 0);

`ifdef RISCV_V_PERM_PERF_EN
        chk("perf_v2i", {96'h0, perf_v2i_cnt}, m_v2i);
        chk("perf_i2v", {96'h0, perf_i2v_cnt}, m_i2v);
        chk("perf_stall", {96'h0, perf_stall_cnt}, m_stall);
`endif

        // Reset in the middle of EXEC.
        vec_wb_ready = 1'b0;
        issue(1'b0, 1'b1, 32'h0bad_f00d, '0);
        @(negedge clk) chk("abort_in_exec", {126'h0, fsm_state}, 1);
        @(posedge clk) #1 rst_n = 1'b0;
        void'(exp_q.pop_back());
        @(posedge clk);
        @(negedge clk) check_reset();
        @(posedge clk) #1 rst_n = 1'b1;

        // Reset during a writeback stall.
        issue(1'b0, 1'b1, 32'hcafe_0001, '0);
        k = 0;
        do begin @(negedge clk); k++; end while (!vec_wb_valid && k < 40);
        chk("abort_wb_seen", {127'h0, vec_wb_valid}, 1);
        @(posedge clk) #1 rst_n = 1'b0;
        void'(exp_q.pop_back());
        @(posedge clk);
        @(negedge clk) check_reset();
        @(posedge clk) #1 rst_n = 1'b1;

        // Normal op after the aborts.
        vec_wb_ready = 1'b1;
        issue(1'b1, 1'b0, 32'h0, {96'h0, 32'h5a5a_c3c3});
        k = 0;
        while (exp_q.size() != 0 && k < 50) begin @(negedge clk); k++; end
        chk("final_drain", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/riscv_v_permutation_ctrl.md
Name: riscv_v_permutation_ctrl

Overview:
- Sequencing controller in front of the vector permutation ALU (scalar<->vector moves, vmv.x.s / vmv.s.x class).
- Accepts one request at a time from vector issue over valid/ready and drives the ALU control/data inputs for ALU_LAT cycles.
- Captures the ALU result and returns it on the integer or the vector writeback channel, holding it until that channel accepts.

Parameters:
- INT_W, 32, integer (scalar) data width.
- VEC_W, 128, vector ALU data / writeback data width.
- ALU_LAT, 1, cycles the ALU inputs are held before the result is sampled; legal range 1..15.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- req_valid  in  1  issue request valid.
- req_ready  out  1  controller can accept a request.
- req_is_v2i  in  1  request is vector->integer move.
- req_is_i2v  in  1  request is integer->vector move.
- req_int_data  in  INT_W  scalar operand.
- req_vec_data  in  VEC_W  vector operand.
- alu_is_v2i  out  1  to ALU.
- alu_is_i2v  out  1  to ALU.
- alu_int_data  out  INT_W  to ALU.
- alu_vec_data  out  VEC_W  to ALU.
- alu_int_result  in  INT_W  from ALU.
- alu_vec_result  in  VEC_W  from ALU.
- int_wb_valid  out  1  integer writeback valid.
- int_wb_ready  in  1  integer writeback ready.
- int_wb_data  out  INT_W  integer writeback data.
- vec_wb_valid  out  1  vector writeback valid.
- vec_wb_ready  in  1  vector writeback ready.
- vec_wb_data  out  VEC_W  vector writeback data.
- illegal_req  out  1  one-cycle pulse on a rejected request.

Behaviour:
- Clock is clk; reset is rst_n, synchronous, active-low. All state updates on posedge clk only.
- Reset values: state=IDLE; req_ready=1; all alu_* outputs=0; int_wb_valid=0, vec_wb_valid=0; wb data=0; illegal_req=0; counter=0.
- FSM states: IDLE, EXEC, WB.
- IDLE:
  - req_ready=1. A request is accepted when req_valid & req_ready.
  - Legal request (exactly one of req_is_v2i / req_is_i2v set): latch flags and both operands, load counter=ALU_LAT-1, go to EXEC.
  - Illegal request (both set or neither set): consume it, pulse illegal_req the next cycle, stay in IDLE. No writeback is produced.
- EXEC:
  - req_ready=0. alu_* outputs driven from the latched values, stable for ALU_LAT cycles.
  - Counter decrements each cycle. When counter==0, sample alu_int_result (v2i) or alu_vec_result (i2v) into the wb data register and go to WB.
  - In all states other than EXEC, alu_* outputs are 0.
- WB:
  - v2i: int_wb_valid=1. i2v: vec_wb_valid=1. The two valids are never high together.
  - wb data stays stable while valid & !ready.
  - When valid & ready, drop valid and go to IDLE.
  - The next request can be accepted in the cycle after the handshake. No same-cycle pass-through.
- Latency: request handshake at cycle T -> wb valid asserted at cycle T+ALU_LAT+1. Throughput is one op per ALU_LAT+2 cycles with ready held high.
- A wb ready asserted while valid is low has no effect. A ready on the channel not in use is ignored.
- rst_n low in any state (mid-EXEC or mid-WB) aborts the op: outputs return to reset values the next cycle and no writeback is emitted.

Optional Feature:
- Macro RISCV_V_PERM_PERF_EN.
- Defined: adds outputs perf_v2i_cnt[31:0], perf_i2v_cnt[31:0] and perf_stall_cnt[31:0].
  - perf_v2i_cnt / perf_i2v_cnt increment on each completed wb handshake of the matching type.
  - perf_stall_cnt increments on each WB cycle with valid & !ready.
  - All three clear on reset and wrap at 2^32-1 -> 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then v2i request with req_vec_data=0x...DEAD_BEEF, ALU_LAT=1, ALU returning 0xDEADBEEF, int_wb_ready=1 -> alu_is_v2i=1 for exactly 1 cycle; int_wb_valid at T+2 with data 0xDEADBEEF; vec_wb_valid stays 0.
- i2v with req_int_data=0x12345678, ALU returning 0x...12345678, ALU_LAT=3, vec_wb_ready low for 4 cycles -> vec_wb_valid at T+4, held with stable data for 4 cycles, then drops after the handshake; req_ready=0 throughout.
- Request with both flags set, then with neither set -> illegal_req pulses once per request; no alu activity; no wb valid; req_ready stays 1.
- Back-to-back legal requests with req_valid held high and wb ready=1 -> accepts spaced exactly ALU_LAT+2 cycles apart; results returned in order.
- Assert rst_n=0 during EXEC and again during WB stall -> next cycle all outputs at reset values; no wb handshake; next request accepted normally.
- With RISCV_V_PERM_PERF_EN: 3 v2i ops, 2 i2v ops and 5 stall cycles -> counters read 3/2/5; all 0 after reset.
